surf_img_rd_arb: RTL
====================

Name: surf_img_rd_arb

Overview:
- Parametrised image-memory read engine for the SURF accelerator; successor to fixed two-port (a/b) image memory access.
- NUM_CH internal requesters (detector, descriptor, orientation units) each submit a burst read: start address plus length.
- Bursts are scheduled with per-port round-robin arbitration onto NUM_PORTS image-memory read ports with fixed read latency RD_LAT.
- Read data is returned to each channel in order, with a last-word flag.

Parameters:
- NUM_CH, 4: number of requesting channels; 1..8. Channel c is served by memory port c % NUM_PORTS.
- NUM_PORTS, 2: number of image memory read ports; 1..NUM_CH.
- ADDR_W, 17: memory address width.
- DATA_W, 24: pixel word width (RGB888).
- LEN_W, 10: burst length field width. req_len = words-1.
- MEM_DEPTH, 76800: valid word count. Addresses wrap to 0 after MEM_DEPTH-1.
- RD_LAT, 1: memory read latency in cycles; 1..4.

Ports:
- clk  in  1  clock, all logic rising-edge.
- rst  in  1  reset. Asynchronous assertion, active-low.
- req_valid  in  NUM_CH  per-channel burst request.
- req_ready  out  NUM_CH  channel idle and accepting a request.
- req_addr  in  NUM_CH*ADDR_W  burst start address. Channel c occupies bits [c*ADDR_W +: ADDR_W].
- req_len  in  NUM_CH*LEN_W  burst words minus 1.
- rsp_valid  out  NUM_CH  read data valid. Single-cycle pulse per word; no backpressure.
- rsp_data  out  NUM_CH*DATA_W  read data.
- rsp_last  out  NUM_CH  final word of burst, qualified by rsp_valid.
- busy  out  NUM_CH  channel has a burst in progress.
- mem_en  out  NUM_PORTS  memory read enable.
- mem_addr  out  NUM_PORTS*ADDR_W  memory read address.
- mem_dout  in  NUM_PORTS*DATA_W  memory read data, valid RD_LAT cycles after the mem_en cycle.

Behaviour:
- Reset (rst=0): all outputs 0, including req_ready. All channel states are set to IDLE and arbiter pointers to 0. In-flight reads are discarded and produce no rsp_valid.
- req_ready rises in the first cycle after reset release.
- Channel FSM:
  - IDLE: req_ready=1.
    - Accept on req_valid&req_ready: latch cur_addr=req_addr and remaining=req_len, then go to ISSUE.
  - ISSUE: busy=1, req_ready=0.
    - On each grant: cur_addr advances. If cur_addr==MEM_DEPTH-1, next is 0; otherwise +1.
    - On each grant: remaining decrements.
    - The grant issued with remaining==0 is tagged last; go to DRAIN.
  - DRAIN: busy=1. Wait for the tagged-last response.
    - In the cycle rsp_last is driven, the state goes to IDLE.
    - req_ready=1 from the next cycle.
- Arbitration, per port:
  - Candidates are channels mapped to that port and in ISSUE.
  - Round-robin starting at pointer. After a grant, pointer = granted index + 1 (mod channels on that port).
  - A single active channel is granted every cycle, giving full throughput.
- Memory interface:
  - mem_en/mem_addr are registered.
  - A request accepted in cycle T gets its first mem_en no earlier than T+1.
  - mem_en=0 when there is no grant; mem_addr holds its last value.
- Response pipeline, per port: an RD_LAT-deep shift register of {valid, channel id, last}. mem_dout is registered.
  - mem_en in cycle G gives rsp_valid/rsp_data in cycle G+RD_LAT+1, routed to the tagged channel.
  - rsp_data for non-pulsing channels holds its previous value.
- Out-of-range start address (req_addr >= MEM_DEPTH):
  - Accepted, and addresses are issued unchanged until they reach the wrap point at MEM_DEPTH-1.
  - Sets no error flag. Upstream must not generate it.
- Simultaneous req_valid on several channels: all idle channels accept in the same cycle.
- Length 0 (req_len=0): exactly one read, with rsp_last on that word.
- Reset asserted mid-burst: immediate clear as above. After release, no stale responses appear.

Decomposition:
- Package surf_rd_pkg contains:
  - chan_state_t enum {IDLE, ISSUE, DRAIN}.
  - Constants RD_LAT_MAX=4 and NUM_CH_MAX=8.
  - A typedef for the response tag struct {valid, ch_id, last}.
  - Function next_addr(addr, depth) implementing the wrap rule.
- Sub-module surf_rr_arbiter (parameter N): request vector in, one-hot grant and grant index out, internal rotating pointer, async active-low reset. One instance per port.

Test Plan:
- Single-channel burst: NUM_CH=4, NUM_PORTS=2, RD_LAT=1; ch0 addr=100, len=3.
  - mem_en on port0 for 4 consecutive cycles, mem_addr=100..103.
  - rsp_valid on ch0 for 4 consecutive cycles, starting 2 cycles after the first mem_en; rsp_last on the 4th word.
  - req_ready high in the cycle after rsp_last.
- Round-robin sharing: ch0 addr=0 and ch2 addr=500 (both port0), len=1, accepted in the same cycle.
  - port0 addresses 0,500,1,501 in alternating grants.
  - ch1 addr=200 runs concurrently on port1 with 2 reads back to back.
- Wrap-around: ch1 addr=76798, len=3.
  - mem_addr sequence 76798, 76799, 0, 1.
- Latency: repeat the single-channel burst with RD_LAT=3.
  - First rsp_valid arrives 4 cycles after the first mem_en.
  - Data matches the memory model's address-to-pixel pattern.
- Reset mid-burst: rst low for 2 cycles during ch0 len=15 after 5 grants.
  - All outputs are 0 during reset.
  - No rsp_valid appears after release.
  - req_ready=1 from the first cycle after release.
  - A new burst completes normally.
- Length 0 plus back-to-back: ch3 len=0 at addr 7, then a new request the cycle req_ready reasserts.
  - One word with rsp_valid and rsp_last together.
  - The second burst is accepted without loss.

Source files
------------

// File: rtl/surf_rd_pkg.sv
// Shared types and helpers for the SURF image-memory read engine.
//   chan_state_t : per-channel burst state (IDLE / ISSUE / DRAIN)
//   rd_tag_t     : response tag carried alongside each memory read
//   next_addr    : sequential address step with wrap at the end of memory
package surf_rd_pkg;

  localparam int RD_LAT_MAX = 4;
  localparam int NUM_CH_MAX = 8;
  localparam int CH_ID_W    = $clog2(NUM_CH_MAX);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } chan_state_t;

  typedef struct packed {
    logic               valid;
    logic [CH_ID_W-1:0] ch_id;
    logic               last;
  } rd_tag_t;

  // The last valid word wraps to 0; any other address (including one past the
  // end of memory) simply increments.
  function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [31:0] depth);
    if (addr == depth - 32'd1) return 32'd0;
    return addr + 32'd1;
  endfunction

endpackage

// File: rtl/surf_rr_arbiter.sv
// Round-robin arbiter with a rotating priority pointer.
//   clk, rst : clock, asynchronous active-low reset
//   req      : request vector
//   gnt      : one-hot grant (all zero when nothing requests)
//   gnt_idx  : index of the granted requester
// After a grant the pointer moves to the requester just after the winner, so a
// lone active requester is granted every cycle.
module surf_rr_arbiter #(
  parameter int N = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  logic [IW-1:0] ptr;
  int            off;
  int            best_off;

  // Winner is the requester at the smallest circular distance from ptr.
  always_comb begin
    gnt_idx  = '0;
    off      = 0;
    best_off = N;
    for (int j = 0; j < N; j++) begin
      off = (j >= int'(ptr)) ? (j - int'(ptr)) : (j + N - int'(ptr));
      if (req[j] && (off < best_off)) begin
        best_off = off;
        gnt_idx  = IW'(j);
      end
    end
    for (int j = 0; j < N; j++) begin
      gnt[j] = (best_off < N) && (gnt_idx == IW'(j));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= '0;
    end else if (|gnt) begin
      ptr <= (int'(gnt_idx) == N - 1) ? '0 : gnt_idx + IW'(1);
    end
  end

endmodule

// File: rtl/surf_img_rd_arb.sv
// SURF image-memory read engine: NUM_CH burst requesters share NUM_PORTS
// fixed-latency read ports (channel c uses port c % NUM_PORTS).
//   clk, rst             : clock, asynchronous active-low reset
//   req_valid/req_ready  : per-channel burst handshake
//   req_addr, req_len    : burst start address and word count minus 1
//   rsp_valid/data/last  : per-channel in-order read data, last-word flag
//   busy                 : channel has a burst in progress
//   mem_en, mem_addr     : registered memory read requests per port
//   mem_dout             : memory data, RD_LAT cycles after mem_en
module surf_img_rd_arb
  import surf_rd_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = 17,
  parameter int DATA_W    = 24,
  parameter int LEN_W     = 10,
  parameter int MEM_DEPTH = 76800,
  parameter int RD_LAT    = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_CH-1:0]           req_valid,
  output logic [NUM_CH-1:0]           req_ready,
  input  logic [NUM_CH*ADDR_W-1:0]    req_addr,
  input  logic [NUM_CH*LEN_W-1:0]     req_len,
  output logic [NUM_CH-1:0]           rsp_valid,
  output logic [NUM_CH*DATA_W-1:0]    rsp_data,
  output logic [NUM_CH-1:0]           rsp_last,
  output logic [NUM_CH-1:0]           busy,
  output logic [NUM_PORTS-1:0]        mem_en,
  output logic [NUM_PORTS*ADDR_W-1:0] mem_addr,
  input  logic [NUM_PORTS*DATA_W-1:0] mem_dout
);

  chan_state_t       state     [NUM_CH];
  chan_state_t       state_nxt [NUM_CH];
  logic [ADDR_W-1:0] cur_addr  [NUM_CH];
  logic [LEN_W-1:0]  remaining [NUM_CH];
  logic [NUM_CH-1:0] issuing;
  logic [NUM_CH-1:0] accept;
  logic [NUM_CH-1:0] gnt_ch;
  rd_tag_t           tail_tag  [NUM_PORTS];
  // Holds req_ready low until the first clock edge after reset release.
  logic              rdy_en;

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      issuing[c] = (state[c] == ISSUE);
    end
  end

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      state_nxt[c] = state[c];
      req_ready[c] = 1'b0;
      busy[c]      = 1'b0;
      accept[c]    = 1'b0;
      case (state[c])
        IDLE: begin
          req_ready[c] = rdy_en;
          accept[c]    = rdy_en & req_valid[c];
          if (accept[c]) state_nxt[c] = ISSUE;
        end
        ISSUE: begin
          busy[c] = 1'b1;
          if (gnt_ch[c] && (remaining[c] == '0)) state_nxt[c] = DRAIN;
        end
        DRAIN: begin
          busy[c] = 1'b1;
          if (rsp_last[c]) state_nxt[c] = IDLE;
        end
        default: state_nxt[c] = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdy_en <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) state[c] <= IDLE;
    end else begin
      rdy_en <= 1'b1;
      for (int c = 0; c < NUM_CH; c++) state[c] <= state_nxt[c];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        cur_addr[c]  <= '0;
        remaining[c] <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (accept[c]) begin
          cur_addr[c]  <= req_addr[c*ADDR_W +: ADDR_W];
          remaining[c] <= req_len[c*LEN_W +: LEN_W];
        end else if (gnt_ch[c]) begin
          cur_addr[c]  <= ADDR_W'(next_addr(32'(cur_addr[c]), 32'(MEM_DEPTH)));
          remaining[c] <= remaining[c] - LEN_W'(1);
        end
      end
    end
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    localparam int NP = (NUM_CH - p + NUM_PORTS - 1) / NUM_PORTS;
    localparam int IW = (NP > 1) ? $clog2(NP) : 1;

    logic [NP-1:0]      req_l;
    logic [NP-1:0]      gnt_l;
    logic [IW-1:0]      idx_l;
    logic [ADDR_W-1:0]  sel_addr;
    logic               sel_last;
    logic [CH_ID_W-1:0] sel_id;
    logic               en_p0;
    logic [ADDR_W-1:0]  addr_p0;
    rd_tag_t            tag_pipe [RD_LAT+1];

    // Local index k on this port is global channel p + k*NUM_PORTS.
    for (genvar k = 0; k < NP; k++) begin : g_map
      assign req_l[k]              = issuing[p + k*NUM_PORTS];
      assign gnt_ch[p + k*NUM_PORTS] = gnt_l[k];
    end

    surf_rr_arbiter #(.N(NP)) u_arb (
      .clk     (clk),
      .rst     (rst),
      .req     (req_l),
      .gnt     (gnt_l),
      .gnt_idx (idx_l)
    );

    always_comb begin
      sel_addr = '0;
      sel_last = 1'b0;
      for (int k = 0; k < NP; k++) begin
        if (gnt_l[k]) begin
          sel_addr = cur_addr[p + k*NUM_PORTS];
          sel_last = (remaining[p + k*NUM_PORTS] == '0);
        end
      end
    end

    assign sel_id = CH_ID_W'(p) + CH_ID_W'(idx_l) * CH_ID_W'(NUM_PORTS);

    // Stage p0: memory request registered; its tag enters the latency pipe.
    // tag_pipe[RD_LAT] lines up with mem_dout for that request.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        en_p0   <= 1'b0;
        addr_p0 <= '0;
        for (int i = 0; i <= RD_LAT; i++) tag_pipe[i] <= '0;
      end else begin
        en_p0 <= |gnt_l;
        if (|gnt_l) addr_p0 <= sel_addr;
        tag_pipe[0] <= '{valid: (|gnt_l), ch_id: sel_id, last: sel_last};
        for (int i = 1; i <= RD_LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
      end
    end

    assign mem_en[p]                    = en_p0;
    assign mem_addr[p*ADDR_W +: ADDR_W] = addr_p0;
    assign tail_tag[p]                  = tag_pipe[RD_LAT];
  end

  // Stage p1: memory data captured and steered to the tagged channel.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_valid <= '0;
      rsp_last  <= '0;
      rsp_data  <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        rsp_valid[c] <= 1'b0;
        rsp_last[c]  <= 1'b0;
        if (tail_tag[c % NUM_PORTS].valid && (int'(tail_tag[c % NUM_PORTS].ch_id) == c)) begin
          rsp_valid[c]                  <= 1'b1;
          rsp_last[c]                   <= tail_tag[c % NUM_PORTS].last;
          rsp_data[c*DATA_W +: DATA_W] <= mem_dout[(c % NUM_PORTS)*DATA_W +: DATA_W];
        end
      end
    end
  end

endmodule
